// File: rtl/pic_vga_scan_if.sv
// Picture-RAM read port, picture-ready level and VGA DAC outputs of the scan-out stage.
interface pic_vga_scan_if;
    logic        pic_ready;
    logic [23:0] rd_data;
    logic [16:0] rd_addr;
    logic        rd_en;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_de;
    logic        frame_start;

    modport master (
        input  pic_ready, rd_data,
        output rd_addr, rd_en, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de, frame_start
    );

    modport slave (
        output pic_ready, rd_data,
        input  rd_addr, rd_en, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de, frame_start
    );
endinterface

// File: rtl/pic_vga_scan.sv
// VGA scan-out of the picture RAM: centred image, black border, black until a complete
// picture is latched at frame start. Colour, enable and syncs lag the counters by 2 pixels.
module pic_vga_scan #(
    parameter int CLK_DIV = 2,
    parameter int IMG_W   = 480,
    parameter int IMG_H   = 270,
    parameter int X0      = 80,
    parameter int Y0      = 105,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SW    = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SW    = 2,
    parameter int V_BP    = 33
) (
    input  logic           clk,
    input  logic           rst_n,
    pic_vga_scan_if.master bus
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST = 10'(H_VIS + H_FP + H_SW + H_BP - 1);
    localparam logic [9:0] V_LAST = 10'(V_VIS + V_FP + V_SW + V_BP - 1);
    localparam logic [9:0] H_VIS_L = 10'(H_VIS);
    localparam logic [9:0] V_VIS_L = 10'(V_VIS);
    localparam logic [9:0] IMG_X0 = 10'(X0);
    localparam logic [9:0] IMG_X1 = 10'(X0 + IMG_W);
    localparam logic [9:0] IMG_Y0 = 10'(Y0);
    localparam logic [9:0] IMG_Y1 = 10'(Y0 + IMG_H);
    localparam logic [9:0] HS_BEG = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END = 10'(H_VIS + H_FP + H_SW);
    localparam logic [9:0] VS_BEG = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END = 10'(V_VIS + V_FP + V_SW);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d, v_q, v_d;
    logic [16:0]      addr_q, addr_d, rd_addr_q, rd_addr_d;
    logic             show_q, show_d, rd_en_q, rd_en_d;
    logic             img_p1_q, img_p1_d, vis_p1_q, vis_p1_d;
    logic             hs_p1_q, hs_p1_d, vs_p1_q, vs_p1_d;
    logic [23:0]      rgb_q, rgb_d;
    logic             de_q, de_d, hs_q, hs_d, vs_q, vs_d;
    logic             pix_en, frame_start, vis, img, hs_n, vs_n;

    // frame_start covers the whole first clk at (0,0), including the clk right after reset release.
    always_comb begin
        pix_en      = (div_q == DIV_LAST);
        frame_start = rst_n && (div_q == '0) && (h_q == '0) && (v_q == '0);
        vis         = (h_q < H_VIS_L) && (v_q < V_VIS_L);
        img         = vis && (h_q >= IMG_X0) && (h_q < IMG_X1) && (v_q >= IMG_Y0) && (v_q < IMG_Y1);
        hs_n        = !((h_q >= HS_BEG) && (h_q < HS_END));
        vs_n        = !((v_q >= VS_BEG) && (v_q < VS_END));
    end

    always_comb begin
        div_d     = pix_en ? '0 : div_q + DIV_W'(1);
        h_d       = h_q;
        v_d       = v_q;
        show_d    = frame_start ? bus.pic_ready : show_q;
        addr_d    = addr_q;
        rd_addr_d = rd_addr_q;
        rd_en_d   = 1'b0;
        img_p1_d  = img_p1_q;
        vis_p1_d  = vis_p1_q;
        hs_p1_d   = hs_p1_q;
        vs_p1_d   = vs_p1_q;
        rgb_d     = rgb_q;
        de_d      = de_q;
        hs_d      = hs_q;
        vs_d      = vs_q;

        if (pix_en) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end

        // Only image pixels advance the address, so rows land contiguously in the RAM.
        if (frame_start) begin
            addr_d = '0;
        end else if (pix_en && img) begin
            addr_d    = addr_q + 17'd1;
            rd_addr_d = addr_q;
            rd_en_d   = 1'b1;
        end

        if (pix_en) begin
            img_p1_d = img;
            vis_p1_d = vis;
            hs_p1_d  = hs_n;
            vs_p1_d  = vs_n;
            rgb_d    = (img_p1_q && show_q) ? bus.rd_data : '0;
            de_d     = vis_p1_q;
            hs_d     = hs_p1_q;
            vs_d     = vs_p1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            h_q       <= '0;
            v_q       <= '0;
            addr_q    <= '0;
            show_q    <= 1'b0;
            rd_addr_q <= '0;
            rd_en_q   <= 1'b0;
            img_p1_q  <= 1'b0;
            vis_p1_q  <= 1'b0;
            hs_p1_q   <= 1'b1;
            vs_p1_q   <= 1'b1;
            rgb_q     <= '0;
            de_q      <= 1'b0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
        end else begin
            div_q     <= div_d;
            h_q       <= h_d;
            v_q       <= v_d;
            addr_q    <= addr_d;
            show_q    <= show_d;
            rd_addr_q <= rd_addr_d;
            rd_en_q   <= rd_en_d;
            img_p1_q  <= img_p1_d;
            vis_p1_q  <= vis_p1_d;
            hs_p1_q   <= hs_p1_d;
            vs_p1_q   <= vs_p1_d;
            rgb_q     <= rgb_d;
            de_q      <= de_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
        end
    end

    assign bus.rd_addr     = rd_addr_q;
    assign bus.rd_en       = rd_en_q;
    assign bus.vga_r       = rgb_q[23:16];
    assign bus.vga_g       = rgb_q[15:8];
    assign bus.vga_b       = rgb_q[7:0];
    assign bus.vga_de      = de_q;
    assign bus.vga_hs      = hs_q;
    assign bus.vga_vs      = vs_q;
    assign bus.frame_start = frame_start;

endmodule

// File: tb/tb_pic_vga_scan.sv
// Bench for pic_vga_scan: a shrunken-timing instance for whole-frame behaviour and a
// default 640x480 instance for first-line timing after reset release.
module tb_pic_vga_scan;

    localparam int S_HV = 16, S_HF = 2, S_HS = 3, S_HB = 3;
    localparam int S_VV = 12, S_VF = 1, S_VS = 2, S_VB = 2;
    localparam int S_IW = 8, S_IH = 6, S_X0 = 4, S_Y0 = 3;
    localparam int S_HT = S_HV + S_HF + S_HS + S_HB;
    localparam int S_VT = S_VV + S_VF + S_VS + S_VB;
    localparam int FRAME = S_HT * S_VT;
    localparam int FR2 = 2 * FRAME;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pic_vga_scan_if s_if ();
    pic_vga_scan_if d_if ();

    pic_vga_scan #(
        .CLK_DIV(2), .IMG_W(S_IW), .IMG_H(S_IH), .X0(S_X0), .Y0(S_Y0),
        .H_VIS(S_HV), .H_FP(S_HF), .H_SW(S_HS), .H_BP(S_HB),
        .V_VIS(S_VV), .V_FP(S_VF), .V_SW(S_VS), .V_BP(S_VB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(s_if.master)
    );

    pic_vga_scan dut_def (
        .clk(clk), .rst_n(rst_n), .bus(d_if.master)
    );

    assign d_if.rd_data   = '0;
    assign d_if.pic_ready = 1'b0;

    // RAM stand-in: returns its own address one clk after the read strobe.
    always @(posedge clk) begin
        if (s_if.rd_en) s_if.rd_data <= 24'(s_if.rd_addr);
    end

    int tests_run = 0;
    int tests_failed = 0;
    int n_run = -1;
    int gf = 0;
    int sb_err = 0;
    int err_n = 0;
    logic [28:0] err_got, err_exp;
    logic show_exp = 1'b0;
    int st_rd [16], st_last [16], st_first_n [16], st_first_a [16];
    int st_de [16], st_hs [16], st_vs [16], st_nz [16];

    function automatic bit is_img(input int p);
        int h = p % S_HT;
        int v = p / S_HT;
        return (h >= S_X0) && (h < S_X0 + S_IW) && (v >= S_Y0) && (v < S_Y0 + S_IH);
    endfunction

    function automatic int img_addr(input int p);
        return (p / S_HT - S_Y0) * S_IW + (p % S_HT - S_X0);
    endfunction

    // Timing model: negedge n after release shows pixel n/2-2 and the read issued for pixel n/2-1.
    always @(negedge clk) begin : mon
        int q, rel;
        logic [23:0] e_rgb;
        logic [16:0] e_addr;
        logic e_de, e_hs, e_vs, e_rd, e_fs, a_chk;
        logic [28:0] got, expv;
        e_rgb = '0; e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_rd = 1'b0; e_fs = 1'b0;
        a_chk = 1'b1; e_addr = '0;
        if (!rst_n) begin
            n_run = -1;
        end else begin
            n_run++;
            rel = n_run % FR2;
            if (rel == 0) begin
                gf++;
                show_exp = s_if.pic_ready;
                if (gf < 16) begin
                    st_rd[gf] = 0; st_last[gf] = -1; st_first_n[gf] = -1; st_first_a[gf] = -1;
                    st_de[gf] = 0; st_hs[gf] = 0; st_vs[gf] = 0; st_nz[gf] = 0;
                end
            end
            e_fs  = (rel == 0);
            a_chk = 1'b0;
            if (n_run >= 2 && n_run % 2 == 0) begin
                q = (n_run / 2 - 1) % FRAME;
                if (is_img(q)) begin
                    e_rd = 1'b1; a_chk = 1'b1; e_addr = 17'(img_addr(q));
                end
            end
            if (n_run >= 4) begin
                q = (n_run / 2 - 2) % FRAME;
                e_de = ((q % S_HT) < S_HV) && ((q / S_HT) < S_VV);
                e_hs = !(((q % S_HT) >= S_HV + S_HF) && ((q % S_HT) < S_HV + S_HF + S_HS));
                e_vs = !(((q / S_HT) >= S_VV + S_VF) && ((q / S_HT) < S_VV + S_VF + S_VS));
                if (is_img(q) && show_exp) e_rgb = 24'(img_addr(q));
            end
            if (gf < 16) begin
                if (s_if.rd_en) begin
                    st_rd[gf]++;
                    st_last[gf] = int'(s_if.rd_addr);
                    if (st_first_n[gf] < 0) begin
                        st_first_n[gf] = rel;
                        st_first_a[gf] = int'(s_if.rd_addr);
                    end
                end
                if (s_if.vga_de) st_de[gf]++;
                if (!s_if.vga_hs) st_hs[gf]++;
                if (!s_if.vga_vs) st_vs[gf]++;
                if ({s_if.vga_r, s_if.vga_g, s_if.vga_b} != 24'd0) st_nz[gf]++;
            end
        end
        got  = {s_if.vga_r, s_if.vga_g, s_if.vga_b, s_if.vga_de, s_if.vga_hs, s_if.vga_vs,
                s_if.rd_en, s_if.frame_start};
        expv = {e_rgb, e_de, e_hs, e_vs, e_rd, e_fs};
        if ((got !== expv) || (a_chk && (s_if.rd_addr !== e_addr))) begin
            sb_err++;
            if (sb_err == 1) begin
                err_n = n_run; err_got = got; err_exp = expv;
            end
        end
    end

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        assert (got === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic apply_stimulus(input logic rdy, input logic rstn);
        @(posedge clk);
        #2;
        s_if.pic_ready = rdy;
        rst_n = rstn;
    endtask

    task automatic wait_frame(input int k);
        int guard = 0;
        while (gf < k && guard < 3 * FR2) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check_output($sformatf("frame_%0d_reached", k), 32'(gf >= k), 32'd1);
    endtask

    task automatic wait_pos(input int r);
        int guard = 0;
        do begin
            @(negedge clk);
            #1;
            guard++;
        end while ((n_run % FR2) != r && guard < 2 * FR2);
        check_output("position_reached", 32'(n_run % FR2), 32'(r));
    endtask

    initial begin
        int k_de_on, k_de_off, k_hs;
        k_de_on = -1; k_de_off = -1; k_hs = -1;
        s_if.pic_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_output("rst_rgb", 32'({s_if.vga_r, s_if.vga_g, s_if.vga_b}), 32'd0);
        check_output("rst_hs", 32'(s_if.vga_hs), 32'd1);
        check_output("rst_vs", 32'(s_if.vga_vs), 32'd1);
        check_output("rst_de", 32'(s_if.vga_de), 32'd0);
        check_output("rst_rd_en", 32'(s_if.rd_en), 32'd0);
        check_output("rst_rd_addr", 32'(s_if.rd_addr), 32'd0);
        check_output("rst_frame_start", 32'(s_if.frame_start), 32'd0);
        check_output("def_rst_hs", 32'(d_if.vga_hs), 32'd1);
        check_output("def_rst_vs", 32'(d_if.vga_vs), 32'd1);
        check_output("def_rst_de", 32'(d_if.vga_de), 32'd0);

        rst_n = 1'b1;
        #1;
        check_output("first_frame_start", 32'(s_if.frame_start), 32'd1);
        check_output("def_first_frame_start", 32'(d_if.frame_start), 32'd1);

        for (int k = 1; k <= 1400; k++) begin
            @(posedge clk);
            #1;
            if (d_if.vga_de && k_de_on < 0) k_de_on = k;
            if (!d_if.vga_de && k_de_on >= 0 && k_de_off < 0) k_de_off = k;
            if (!d_if.vga_hs && k_hs < 0) k_hs = k;
        end
        check_output("def_de_rise_clk", 32'(k_de_on), 32'd4);
        check_output("def_de_fall_clk", 32'(k_de_off), 32'd1284);
        check_output("def_hs_fall_clk", 32'(k_hs), 32'd1316);

        apply_stimulus(1'b0, 1'b1);
        wait_frame(3);
        check_output("f1_reads", 32'(st_rd[1]), 32'd48);
        check_output("f1_last_addr", 32'(st_last[1]), 32'd47);
        check_output("f1_first_rd_clk", 32'(st_first_n[1]), 32'd154);
        check_output("f1_first_addr", 32'(st_first_a[1]), 32'd0);
        check_output("f1_de_clks", 32'(st_de[1]), 32'd384);
        check_output("f1_hs_low_clks", 32'(st_hs[1]), 32'd102);
        check_output("f1_vs_low_clks", 32'(st_vs[1]), 32'd96);
        check_output("f1_colour_clks", 32'(st_nz[1]), 32'd94);

        wait_frame(4);
        check_output("f2_colour_after_mid_drop", 32'(st_nz[2]), 32'd94);
        check_output("f3_black_colour", 32'(st_nz[3]), 32'd0);
        check_output("f3_black_reads", 32'(st_rd[3]), 32'd48);

        wait_pos(384);
        apply_stimulus(1'b1, 1'b1);
        wait_frame(6);
        check_output("f4_raised_mid_black", 32'(st_nz[4]), 32'd0);
        check_output("f4_reads", 32'(st_rd[4]), 32'd48);
        check_output("f5_colour_clks", 32'(st_nz[5]), 32'd94);
        check_output("f5_last_addr", 32'(st_last[5]), 32'd47);

        wait_pos(256);
        @(posedge clk);
        #2;
        check_output("pre_rst_rgb", 32'({s_if.vga_r, s_if.vga_g, s_if.vga_b}), 32'd18);
        check_output("pre_rst_de", 32'(s_if.vga_de), 32'd1);
        check_output("pre_rst_rd_addr", 32'(s_if.rd_addr), 32'd19);
        rst_n = 1'b0;
        #1;
        check_output("mid_rst_rgb", 32'({s_if.vga_r, s_if.vga_g, s_if.vga_b}), 32'd0);
        check_output("mid_rst_de", 32'(s_if.vga_de), 32'd0);
        check_output("mid_rst_rd_addr", 32'(s_if.rd_addr), 32'd0);
        check_output("mid_rst_hs", 32'(s_if.vga_hs), 32'd1);
        check_output("mid_rst_frame_start", 32'(s_if.frame_start), 32'd0);
        repeat (2) @(posedge clk);
        apply_stimulus(1'b1, 1'b1);

        wait_frame(8);
        check_output("f7_first_rd_clk", 32'(st_first_n[7]), 32'd154);
        check_output("f7_first_addr", 32'(st_first_a[7]), 32'd0);
        check_output("f7_reads", 32'(st_rd[7]), 32'd48);
        check_output("f7_colour_clks", 32'(st_nz[7]), 32'd94);

        check_output($sformatf("scoreboard (first at n=%0d got=%h exp=%h)", err_n, err_got, err_exp),
                     32'(sb_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
